// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory arbiter.
// Holds the FSM state and owner encodings and the grant decision.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  localparam int WAIT_CNT_W = 4;

  // DM is the older instruction and normally wins; a set fair flag hands one turn to IF.
  function automatic arb_owner_t pick_owner(input logic if_req, input logic dm_req,
                                            input logic fair);
    return (dm_req && !(if_req && fair)) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Loadable wait-state down-counter for the memory arbiter.
// Load has priority over decrement; the count never wraps below zero.
module mem_arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between IF and DM.
// Optional feature: define MEM_ARB_FAIR_EN to alternate grants when both ports keep requesting.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_freeze
);

  localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(WAIT_CYCLES - 1);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t grant;
  logic       any_req;
  logic       fair_q;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  assign any_req  = if_req | dm_req;
  assign grant    = pick_owner(if_req, dm_req, fair_q);
  assign cnt_load = (state == IDLE) && any_req;
  assign cnt_dec  = (state == ACCESS);

`ifdef MEM_ARB_FAIR_EN
  // Flag remembers that DM took the last grant, so a waiting fetch goes next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_q <= 1'b0;
    end else if (cnt_load) begin
      fair_q <= (grant == OWN_DM);
    end
  end
`else
  assign fair_q = 1'b0;
`endif

  mem_arb_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // mem_addr/mem_wdata/mem_we are the request latches themselves, so they cannot move mid-access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= grant;
            state  <= ACCESS;
            mem_en <= 1'b1;
            if (grant == OWN_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end else begin
              dm_ready <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pipe_freeze = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule
